// File: rtl/score_overlay.sv
// N-digit packed-BCD score register with an 8x8-font raster overlay (2-cycle pixel pipeline).
// Optional leading-zero blanking is enabled by defining SCORE_OVERLAY_LEADING_ZERO_BLANK_EN.
module score_overlay #(
  parameter int NUM_DIGITS = 4,
  parameter int SCALE_LOG2 = 0,
  parameter int HW         = 11,
  parameter int VW         = 10,
  parameter int X_INIT     = 225,
  parameter int Y_INIT     = 441
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    chipselect,
  input  logic                    write,
  input  logic [2:0]              address,
  input  logic [31:0]             writedata,
  input  logic                    inc_pulse,
  input  logic [HW-1:0]           hcount,
  input  logic [VW-1:0]           vcount,
  input  logic                    pixel_valid,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic                    overflow,
  output logic                    pix_on,
  output logic [23:0]             pix_rgb
);

  localparam int SW          = 4 * NUM_DIGITS;
  localparam int GLYPH_SHIFT = 3 + SCALE_LOG2;
  localparam logic [31:0] BOX_W = 32'(NUM_DIGITS) << GLYPH_SHIFT;
  localparam logic [31:0] BOX_H = 32'd8 << SCALE_LOG2;
  localparam logic [SW-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

`ifdef SCORE_OVERLAY_LEADING_ZERO_BLANK_EN
  localparam bit LZ_BLANK_EN = 1'b1;
`else
  localparam bit LZ_BLANK_EN = 1'b0;
`endif

  logic [HW-1:0] pos_x;
  logic [VW-1:0] pos_y;
  logic          enable;
  logic          wrap;
  logic [23:0]   colour;

  logic          bus_wr;
  logic          unused_bits;
  assign bus_wr      = chipselect && write;
  assign unused_bits = &{1'b0, writedata};

  function automatic logic [7:0] font_row(input logic [3:0] d, input logic [2:0] r);
    logic [63:0] g;
    logic [2:0]  ri;
    case (d)
      4'd0:    g = 64'h3C66_6E7E_7666_3C00;
      4'd1:    g = 64'h1838_1818_1818_7E00;
      4'd2:    g = 64'h3C66_061C_3066_7E00;
      4'd3:    g = 64'h3C66_061C_0666_3C00;
      4'd4:    g = 64'h0C1C_2C4C_7E0C_0C00;
      4'd5:    g = 64'h7E60_7C06_0666_3C00;
      4'd6:    g = 64'h3C66_607C_6666_3C00;
      4'd7:    g = 64'h7E06_0C18_3030_3000;
      4'd8:    g = 64'h3C66_663C_6666_3C00;
      4'd9:    g = 64'h3C66_663E_0666_3C00;
      default: g = 64'h0;
    endcase
    ri = 3'd7 - r;
    return g[{ri, 3'b000} +: 8];
  endfunction

  // Decimal +1 with full ripple; invalid nibbles behave as 9 only when the carry reaches them.
  logic [SW-1:0] inc_score;
  logic          roll;
  logic [3:0]    digit;
  logic [3:0]    clamped;

  always_comb begin
    inc_score = score_bcd;
    roll      = 1'b1;
    digit     = 4'd0;
    clamped   = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit   = score_bcd[4*i +: 4];
      clamped = (digit > 4'd9) ? 4'd9 : digit;
      if (roll) begin
        if (clamped == 4'd9) begin
          inc_score[4*i +: 4] = 4'd0;
        end else begin
          inc_score[4*i +: 4] = clamped + 4'd1;
          roll = 1'b0;
        end
      end
    end
    if (roll) inc_score = wrap ? '0 : ALL_NINES;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_x     <= HW'(X_INIT);
      pos_y     <= VW'(Y_INIT);
      enable    <= 1'b1;
      wrap      <= 1'b0;
      colour    <= '0;
      score_bcd <= '0;
      overflow  <= 1'b0;
    end else begin
      if (bus_wr) begin
        case (address)
          3'd0: pos_x <= writedata[HW-1:0];
          3'd1: pos_y <= writedata[VW-1:0];
          3'd3: begin
            enable <= writedata[0];
            wrap   <= writedata[1];
          end
          3'd4: colour <= writedata[23:0];
          default: ;
        endcase
      end
      // Bus load and clear take priority; a coincident increment is dropped.
      if (bus_wr && address == 3'd2) begin
        score_bcd <= writedata[SW-1:0];
      end else if (bus_wr && address == 3'd3 && writedata[2]) begin
        score_bcd <= '0;
        overflow  <= 1'b0;
      end else if (inc_pulse) begin
        score_bcd <= inc_score;
        if (roll) overflow <= 1'b1;
      end
    end
  end

  logic [HW-1:0] dx;
  logic [VW-1:0] dy;
  logic [HW-1:0] slot;
  logic          inbox;
  assign dx    = hcount - pos_x;
  assign dy    = vcount - pos_y;
  assign slot  = dx >> GLYPH_SHIFT;
  assign inbox = (hcount >= pos_x) && (32'(dx) < BOX_W) &&
                 (vcount >= pos_y) && (32'(dy) < BOX_H);

  // Slot 0 is leftmost, i.e. the most significant nibble.
  logic [3:0] sel_nibble;
  logic       sel_blank;
  logic       zero_prefix;

  always_comb begin
    sel_nibble  = 4'd0;
    sel_blank   = 1'b0;
    zero_prefix = 1'b1;
    for (int s = 0; s < NUM_DIGITS; s++) begin
      zero_prefix = zero_prefix && (score_bcd[4*(NUM_DIGITS-1-s) +: 4] == 4'd0);
      if (slot == HW'(s)) begin
        sel_nibble = score_bcd[4*(NUM_DIGITS-1-s) +: 4];
        sel_blank  = LZ_BLANK_EN && zero_prefix && (s != NUM_DIGITS - 1);
      end
    end
  end

  logic       inbox_d;
  logic       valid_d;
  logic       blank_d;
  logic [3:0] nibble_d;
  logic [2:0] row_d;
  logic [2:0] col_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inbox_d  <= 1'b0;
      valid_d  <= 1'b0;
      blank_d  <= 1'b0;
      nibble_d <= 4'd0;
      row_d    <= 3'd0;
      col_d    <= 3'd0;
    end else begin
      inbox_d  <= inbox;
      valid_d  <= pixel_valid;
      blank_d  <= sel_blank;
      nibble_d <= sel_nibble;
      row_d    <= dy[SCALE_LOG2 +: 3];
      col_d    <= dx[SCALE_LOG2 +: 3];
    end
  end

  logic [7:0] glyph_bits;
  logic       fg;
  assign glyph_bits = font_row(nibble_d, row_d);
  assign fg = glyph_bits[3'd7 - col_d] && inbox_d && valid_d && enable && !blank_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_on  <= 1'b0;
      pix_rgb <= '0;
    end else begin
      pix_on  <= fg;
      pix_rgb <= fg ? colour : 24'h0;
    end
  end

endmodule

// File: tb/tb_score_overlay.sv
// Self-checking bench for score_overlay: behavioural score/font model, scale 1x and 2x instances.
// Honours SCORE_OVERLAY_LEADING_ZERO_BLANK_EN in its model when the build defines it.
module tb_score_overlay;

  localparam int N = 4;

  logic        clk, reset, chipselect, write, inc_pulse, pixel_valid;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [15:0] score_bcd, score_bcd2;
  logic        overflow, overflow2, pix_on, pix_on2;
  logic [23:0] pix_rgb, pix_rgb2;

  score_overlay #(.NUM_DIGITS(N), .SCALE_LOG2(0)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
    .address(address), .writedata(writedata), .inc_pulse(inc_pulse),
    .hcount(hcount), .vcount(vcount), .pixel_valid(pixel_valid),
    .score_bcd(score_bcd), .overflow(overflow), .pix_on(pix_on), .pix_rgb(pix_rgb)
  );

  score_overlay #(.NUM_DIGITS(N), .SCALE_LOG2(1)) dut2 (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
    .address(address), .writedata(writedata), .inc_pulse(inc_pulse),
    .hcount(hcount), .vcount(vcount), .pixel_valid(pixel_valid),
    .score_bcd(score_bcd2), .overflow(overflow2), .pix_on(pix_on2), .pix_rgb(pix_rgb2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        on;
    logic [23:0] rgb;
    logic [10:0] h;
    logic [9:0]  v;
  } exp_t;

  exp_t        q1[$];
  exp_t        q2[$];
  logic [63:0] glyph [10];
  int          tests;
  int          fails;

  int          m_px, m_py;
  logic [15:0] m_bcd;
  logic        m_ovf, m_en, m_wrap;
  logic [23:0] m_col;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic modelReset();
    m_px = 225; m_py = 441; m_bcd = 16'h0; m_ovf = 1'b0;
    m_en = 1'b1; m_wrap = 1'b0; m_col = 24'h0;
  endtask

  function automatic int bcd2int(input logic [15:0] b);
    int v = 0;
    for (int i = N - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] b = 16'h0;
    for (int i = 0; i < N; i++) begin
      b[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return b;
  endfunction

  task automatic modelInc();
    int v = bcd2int(m_bcd);
    if (v == 9999) begin
      m_ovf = 1'b1;
      if (m_wrap) m_bcd = 16'h0;
    end else begin
      m_bcd = int2bcd(v + 1);
    end
  endtask

  function automatic logic expectOn(input int h, input int v, input int scale, input logic valid);
    int dx, dy, slot, col, row;
    logic [3:0]  nib;
    logic [63:0] g;
    if (!valid || !m_en) return 1'b0;
    if (h < m_px || v < m_py) return 1'b0;
    dx = h - m_px;
    dy = v - m_py;
    if (dx >= ((N * 8) << scale) || dy >= (8 << scale)) return 1'b0;
    slot = dx / (8 << scale);
    col  = (dx >> scale) % 8;
    row  = (dy >> scale) % 8;
    nib  = 4'(m_bcd >> (4 * (N - 1 - slot)));
    if (nib > 4'd9) return 1'b0;
`ifdef SCORE_OVERLAY_LEADING_ZERO_BLANK_EN
    if (slot < N - 1 && (m_bcd >> (4 * (N - 1 - slot))) == 16'h0) return 1'b0;
`endif
    g = glyph[nib];
    return g[63 - 8 * row - col];
  endfunction

  task automatic checkScore(input string tag);
    checkOutput({tag, ".score"}, 32'(score_bcd), 32'(m_bcd));
    checkOutput({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    checkOutput({tag, ".score2"}, 32'(score_bcd2), 32'(m_bcd));
  endtask

  task automatic writeReg(input logic [2:0] a, input logic [31:0] d, input logic inc = 1'b0);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d; inc_pulse = inc;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0; inc_pulse = 1'b0;
    if (inc && !(a == 3'd2 || (a == 3'd3 && d[2]))) modelInc();
    case (a)
      3'd0: m_px = int'(d[10:0]);
      3'd1: m_py = int'(d[9:0]);
      3'd2: m_bcd = d[15:0];
      3'd3: begin
        m_en = d[0]; m_wrap = d[1];
        if (d[2]) begin m_bcd = 16'h0; m_ovf = 1'b0; end
      end
      3'd4: m_col = d[23:0];
      default: ;
    endcase
  endtask

  task automatic pulseInc(input int n);
    inc_pulse = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
      modelInc();
    end
    inc_pulse = 1'b0;
  endtask

  // One pixel per cycle; the output after each edge belongs to the pixel driven one call earlier.
  task automatic applyStimulus(input int h, input int v, input logic valid);
    exp_t e;
    hcount = 11'(h); vcount = 10'(v); pixel_valid = valid;
    e.h = 11'(h); e.v = 10'(v);
    e.on = expectOn(h, v, 0, valid); e.rgb = e.on ? m_col : 24'h0; q1.push_back(e);
    e.on = expectOn(h, v, 1, valid); e.rgb = e.on ? m_col : 24'h0; q2.push_back(e);
    @(posedge clk); #1;
    if (q1.size() >= 2) begin
      e = q1.pop_front();
      checkOutput($sformatf("pix_on@%0d,%0d", e.h, e.v), 32'(pix_on), 32'(e.on));
      checkOutput($sformatf("pix_rgb@%0d,%0d", e.h, e.v), 32'(pix_rgb), 32'(e.rgb));
      e = q2.pop_front();
      checkOutput($sformatf("x2.pix_on@%0d,%0d", e.h, e.v), 32'(pix_on2), 32'(e.on));
      checkOutput($sformatf("x2.pix_rgb@%0d,%0d", e.h, e.v), 32'(pix_rgb2), 32'(e.rgb));
    end
  endtask

  task automatic endStream();
    applyStimulus(0, 0, 1'b0);
    applyStimulus(0, 0, 1'b0);
    q1.delete();
    q2.delete();
  endtask

  task automatic sweep(input int h0, input int h1, input int v0, input int v1, input logic valid);
    for (int v = v0; v <= v1; v++)
      for (int h = h0; h <= h1; h++) applyStimulus(h, v, valid);
    endStream();
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int px, py, h, v;
    glyph[0] = 64'h3C666E7E76663C00; glyph[1] = 64'h1838181818187E00;
    glyph[2] = 64'h3C66061C30667E00; glyph[3] = 64'h3C66061C06663C00;
    glyph[4] = 64'h0C1C2C4C7E0C0C00; glyph[5] = 64'h7E607C0606663C00;
    glyph[6] = 64'h3C66607C66663C00; glyph[7] = 64'h7E060C1830303000;
    glyph[8] = 64'h3C66663C66663C00; glyph[9] = 64'h3C66663E06663C00;
    tests = 0; fails = 0;
    reset = 1'b1; chipselect = 1'b0; write = 1'b0; address = 3'd0; writedata = 32'h0;
    inc_pulse = 1'b0; hcount = 11'd0; vcount = 10'd0; pixel_valid = 1'b0;
    modelReset();

    repeat (3) @(posedge clk);
    #1;
    checkScore("reset");
    checkOutput("reset.pix_on", 32'(pix_on), 32'd0);
    checkOutput("reset.pix_rgb", 32'(pix_rgb), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Default position, all-zero score, green
    writeReg(3'd4, 32'h0000FF00);
    sweep(222, 262, 440, 449, 1'b1);

    // Reset in mid-frame on a lit pixel
    applyStimulus(227, 441, 1'b1);
    applyStimulus(227, 441, 1'b1);
    reset = 1'b1;
    #1;
    checkOutput("rst_assert.pix_on", 32'(pix_on), 32'd0);
    checkOutput("rst_assert.pix_rgb", 32'(pix_rgb), 32'd0);
    @(posedge clk); #1;
    checkOutput("rst_hold.pix_on", 32'(pix_on), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_release1.pix_on", 32'(pix_on), 32'd0);
    modelReset();
    q1.delete(); q2.delete();
    endStream();
    checkScore("after_rst");

    // Decimal increments
    writeReg(3'd2, 32'h0199);
    pulseInc(1);
    checkScore("inc_0199");
    writeReg(3'd2, 32'h0009);
    pulseInc(3);
    checkScore("inc3_0009");

    // Saturation, wrap and clear
    writeReg(3'd2, 32'h9999);
    writeReg(3'd3, 32'h1);
    pulseInc(1);
    checkScore("sat_9999");
    writeReg(3'd3, 32'h3);
    pulseInc(1);
    checkScore("wrap_9999");
    writeReg(3'd3, 32'h5);
    checkScore("ctrl_clear");

    // Bus priority over increment, ignored writes
    writeReg(3'd2, 32'h0042, 1'b1);
    checkScore("wr_vs_inc");
    writeReg(3'd3, 32'h5, 1'b1);
    checkScore("clr_vs_inc");
    writeReg(3'd0, 32'd225, 1'b1);
    checkScore("pos_wr_with_inc");
    writeReg(3'd5, 32'h7777);
    checkScore("addr5_ignored");
    chipselect = 1'b0; write = 1'b1; address = 3'd2; writedata = 32'h5555;
    @(posedge clk); #1;
    write = 1'b0;
    checkScore("no_cs_ignored");

    // Origin placement, 1x and 2x glyphs, blanking controls
    writeReg(3'd0, 32'd0);
    writeReg(3'd1, 32'd0);
    writeReg(3'd4, 32'hABCDEF);
    writeReg(3'd2, 32'h1234);
    sweep(0, 66, 0, 17, 1'b1);
    sweep(0, 66, 0, 3, 1'b0);
    writeReg(3'd3, 32'h0);
    sweep(0, 66, 2, 5, 1'b1);
    writeReg(3'd3, 32'h1);
    writeReg(3'd2, 32'h0A35);
    sweep(0, 66, 0, 15, 1'b1);

    // Clipping at the right and bottom counter limits
    writeReg(3'd2, 32'h8888);
    writeReg(3'd0, 32'd2044);
    sweep(2040, 2047, 0, 3, 1'b1);
    sweep(0, 7, 0, 3, 1'b1);
    writeReg(3'd0, 32'd10);
    writeReg(3'd1, 32'd1020);
    sweep(8, 30, 1018, 1023, 1'b1);
    sweep(8, 30, 0, 3, 1'b1);

    // Leading-zero scores
    writeReg(3'd0, 32'd225);
    writeReg(3'd1, 32'd441);
    writeReg(3'd2, 32'h0035);
    sweep(225, 257, 441, 448, 1'b1);
    writeReg(3'd2, 32'h0000);
    sweep(225, 257, 441, 448, 1'b1);

    // Randomised scores, increments and pixel probes
    for (int it = 0; it < 25; it++) begin
      logic wr_wrap;
      logic [15:0] sc;
      wr_wrap = 1'($urandom_range(0, 1));
      sc = (it % 5 == 0) ? int2bcd(9999 - int'($urandom_range(0, 2)))
                         : int2bcd(int'($urandom_range(0, 9999)));
      writeReg(3'd3, {30'h0, wr_wrap, 1'b1});
      writeReg(3'd2, {16'h0, sc});
      pulseInc(int'($urandom_range(0, 3)));
      checkScore($sformatf("rand%0d", it));
      px = int'($urandom_range(0, 2000));
      py = int'($urandom_range(0, 1000));
      writeReg(3'd0, 32'(px));
      writeReg(3'd1, 32'(py));
      writeReg(3'd4, {8'h0, 24'($urandom)});
      for (int k = 0; k < 30; k++) begin
        h = px + int'($urandom_range(0, 74)) - 4;
        v = py + int'($urandom_range(0, 20)) - 2;
        if (h < 0) h = 0;
        if (h > 2047) h = 2047;
        if (v < 0) v = 0;
        if (v > 1023) v = 1023;
        applyStimulus(h, v, ($urandom_range(0, 7) != 0));
      end
      endStream();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
